page_cache: RTL

Multi-page, tagged successor to the single-page UFM page buffer. Caches NUM_PAGES pages of PAGE_WORDS words fetched from the UFM reader's sequential stream. Serves random-address reads to a downstream consumer such as the UART TX path. On a miss it requests the page from upstream by page number, refills a round-robin victim bank, and then serves the read.

---
 rtl/page_cache_pkg.sv | 27 ++
 rtl/page_cache_ram.sv | 26 ++
 rtl/page_cache.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/page_cache_pkg.sv
// page_cache_pkg: shared types and helpers for the page cache.
//   state_e   - refill FSM encoding (idle / request / fill)
//   clog2     - constant-safe ceiling log2
//   Def*      - offset/tag widths derived from the default geometry
package page_cache_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StReq  = 2'd1,
    StFill = 2'd2
  } state_e;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(n)) r = i + 1;
    end
    return r;
  endfunction

  localparam int unsigned DefPageWords = 16;
  localparam int unsigned DefAddrW     = 15;
  localparam int unsigned DefOffsetW   = clog2(DefPageWords);
  localparam int unsigned DefTagW      = DefAddrW - DefOffsetW;

endpackage

// File: rtl/page_cache_ram.sv
// page_cache_ram: simple dual-port RAM, one synchronous write port, one synchronous read port.
//   clk          - clock
//   we/waddr/wdata - write port (refill side)
//   raddr/rdata  - read port, rdata registered one cycle after raddr
module page_cache_ram
  import page_cache_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 32
) (
  input  logic                      clk,
  input  logic                      we,
  input  logic [clog2(DEPTH)-1:0]   waddr,
  input  logic [DATA_W-1:0]         wdata,
  input  logic [clog2(DEPTH)-1:0]   raddr,
  output logic [DATA_W-1:0]         rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/page_cache.sv
// page_cache: tagged multi-page cache in front of a sequential page stream.
// Random reads are served from NUM_PAGES resident pages; a miss requests the page by number,
// refills a round-robin victim bank word by word, then serves the read.
//   clk, rst                 - clock, synchronous active-high reset
//   addr, read_en            - consumer word address and ready
//   data_rand, rand_valid    - registered read data / valid for current addr
//   flush                    - invalidate all pages, abort any refill
//   page_req/page_num/page_ack - refill request handshake to upstream
//   data_seq/seq_valid/seq_stb - refill word stream (seq_stb asks for next word)
//   busy                     - refill FSM not idle
// Optional feature: define PAGE_CACHE_PREFETCH_EN to prefetch the page following the last
// demand-filled page into the next victim while idle.
module page_cache
  import page_cache_pkg::*;
#(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned PAGE_WORDS = 16,
  parameter int unsigned NUM_PAGES  = 2,
  parameter int unsigned ADDR_W     = 15
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [ADDR_W-1:0]                    addr,
  input  logic                                 read_en,
  output logic [DATA_W-1:0]                    data_rand,
  output logic                                 rand_valid,
  input  logic                                 flush,
  output logic                                 page_req,
  output logic [ADDR_W-clog2(PAGE_WORDS)-1:0]  page_num,
  input  logic                                 page_ack,
  input  logic [DATA_W-1:0]                    data_seq,
  input  logic                                 seq_valid,
  output logic                                 seq_stb,
  output logic                                 busy
);

  localparam int unsigned OffsetW = clog2(PAGE_WORDS);
  localparam int unsigned TagW    = ADDR_W - OffsetW;
  localparam int unsigned BankW   = (NUM_PAGES > 1) ? clog2(NUM_PAGES) : 1;
  localparam int unsigned Depth   = NUM_PAGES * PAGE_WORDS;
  localparam int unsigned RamAw   = clog2(Depth);

  state_e                 state_q, state_d;
  logic [NUM_PAGES-1:0]   valid_q, valid_d;
  logic [TagW-1:0]        tag_q [NUM_PAGES];
  logic [TagW-1:0]        tag_d [NUM_PAGES];
  logic [BankW-1:0]       victim_q, victim_d;
  logic [OffsetW-1:0]     cnt_q, cnt_d;
  logic [TagW-1:0]        page_num_q, page_num_d;
  logic                   rand_valid_q, rand_valid_d;
  logic                   seq_stb_q, seq_stb_d;
  logic                   start_q, start_d;

  logic [TagW-1:0]        addr_tag;
  logic [OffsetW-1:0]     addr_off;
  logic                   hit;
  logic [BankW-1:0]       hit_bank;
  logic [BankW-1:0]       victim_next;
  logic                   ram_we;
  logic [DATA_W-1:0]      ram_rdata;

`ifdef PAGE_CACHE_PREFETCH_EN
  logic [TagW-1:0]        last_tag_q, last_tag_d;
  logic                   pf_arm_q, pf_arm_d;
  logic                   pf_fill_q, pf_fill_d;
  logic [TagW-1:0]        next_tag;
  logic                   next_res;
`endif

  assign addr_tag = addr[ADDR_W-1:OffsetW];
  assign addr_off = addr[OffsetW-1:0];

  always_comb begin
    hit      = 1'b0;
    hit_bank = '0;
    for (int b = 0; b < NUM_PAGES; b++) begin
      if (valid_q[b] && (tag_q[b] == addr_tag)) begin
        hit      = 1'b1;
        hit_bank = BankW'(b);
      end
    end
  end

`ifdef PAGE_CACHE_PREFETCH_EN
  always_comb begin
    next_tag = last_tag_q + 1'b1;
    next_res = 1'b0;
    for (int b = 0; b < NUM_PAGES; b++) begin
      if (valid_q[b] && (tag_q[b] == next_tag)) next_res = 1'b1;
    end
  end
`endif

  assign victim_next = (victim_q == BankW'(NUM_PAGES - 1)) ? '0 : victim_q + 1'b1;
  assign ram_we      = (state_q == StFill) && seq_valid && !flush;

  page_cache_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (Depth)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (RamAw'({victim_q, cnt_q})),
    .wdata (data_seq),
    .raddr (RamAw'({hit_bank, addr_off})),
    .rdata (ram_rdata)
  );

  always_comb begin
    state_d    = state_q;
    valid_d    = valid_q;
    tag_d      = tag_q;
    victim_d   = victim_q;
    cnt_d      = cnt_q;
    page_num_d = page_num_q;
    seq_stb_d  = 1'b0;
    start_d    = 1'b0;
    // Drop valid for one cycle after a transfer so the consumer can move addr.
    rand_valid_d = hit && !(read_en && rand_valid_q) && !flush;
`ifdef PAGE_CACHE_PREFETCH_EN
    last_tag_d = last_tag_q;
    pf_arm_d   = pf_arm_q;
    pf_fill_d  = pf_fill_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (!hit && !flush) begin
          page_num_d        = addr_tag;
          valid_d[victim_q] = 1'b0;
          state_d           = StReq;
`ifdef PAGE_CACHE_PREFETCH_EN
          pf_fill_d         = 1'b0;
`endif
        end
`ifdef PAGE_CACHE_PREFETCH_EN
        else if (pf_arm_q && !flush) begin
          pf_arm_d = 1'b0;
          if (!next_res) begin
            page_num_d        = next_tag;
            valid_d[victim_q] = 1'b0;
            state_d           = StReq;
            pf_fill_d         = 1'b1;
          end
        end
`endif
      end
      StReq: begin
        if (page_ack) begin
          state_d = StFill;
          cnt_d   = '0;
          start_d = 1'b1;
        end
      end
      StFill: begin
        if (start_q) seq_stb_d = 1'b1;
        if (seq_valid) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == OffsetW'(PAGE_WORDS - 1)) begin
            valid_d[victim_q] = 1'b1;
            tag_d[victim_q]   = page_num_q;
            victim_d          = victim_next;
            state_d           = StIdle;
`ifdef PAGE_CACHE_PREFETCH_EN
            last_tag_d        = page_num_q;
            pf_arm_d          = !pf_fill_q;
`endif
          end else begin
            seq_stb_d = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (flush) begin
      valid_d   = '0;
      state_d   = StIdle;
      seq_stb_d = 1'b0;
      start_d   = 1'b0;
`ifdef PAGE_CACHE_PREFETCH_EN
      pf_arm_d  = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      valid_q      <= '0;
      for (int b = 0; b < NUM_PAGES; b++) tag_q[b] <= '0;
      victim_q     <= '0;
      cnt_q        <= '0;
      page_num_q   <= '0;
      rand_valid_q <= 1'b0;
      seq_stb_q    <= 1'b0;
      start_q      <= 1'b0;
`ifdef PAGE_CACHE_PREFETCH_EN
      last_tag_q   <= '0;
      pf_arm_q     <= 1'b0;
      pf_fill_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      valid_q      <= valid_d;
      tag_q        <= tag_d;
      victim_q     <= victim_d;
      cnt_q        <= cnt_d;
      page_num_q   <= page_num_d;
      rand_valid_q <= rand_valid_d;
      seq_stb_q    <= seq_stb_d;
      start_q      <= start_d;
`ifdef PAGE_CACHE_PREFETCH_EN
      last_tag_q   <= last_tag_d;
      pf_arm_q     <= pf_arm_d;
      pf_fill_q    <= pf_fill_d;
`endif
    end
  end

  // RAM output has no reset; mask it so data_rand is zero whenever not valid.
  assign data_rand  = rand_valid_q ? ram_rdata : '0;
  assign rand_valid = rand_valid_q;
  assign page_req   = (state_q == StReq);
  assign page_num   = page_num_q;
  assign seq_stb    = seq_stb_q;
  assign busy       = (state_q != StIdle);

endmodule
